sync_queue_counted: RTL and testbench
=====================================

Name: sync_queue_counted

Overview:
- Next-generation synchronous FIFO for pipeline decoupling, such as fetch→decode and the memory request queues.
- Differences from the current queue: full 2**WIDTH capacity (no wasted slot), registered occupancy count, almost-full flag, optional same-cycle fall-through, asynchronous active-low reset.
- Kill flush retained for pipeline squash.
- Single clock domain.

Parameters:
- DATA_SIZE, 32, payload width in bits.
- WIDTH, 4, log2 of depth; capacity = 2**WIDTH entries; legal range 1..8.
- AFULL_LEVEL, 2**WIDTH-2, occupancy at or above which almost_full asserts; legal range 1..2**WIDTH.
- FALLTHROUGH, 0, 1 = write into empty queue is readable in the same cycle; 0 = readable next cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- kill  in  1  synchronous flush; discards all contents.
- wready  out  1  queue can accept a write this cycle.
- wvalid  in  1  write request.
- wdata  in  DATA_SIZE  write payload.
- rready  in  1  consumer takes the head entry this cycle.
- rvalid  out  1  head entry is valid.
- rdata  out  DATA_SIZE  head entry payload.
- count  out  WIDTH+1  registered occupancy, 0..2**WIDTH.
- almost_full  out  1  registered, count >= AFULL_LEVEL.

Behaviour:
- Storage: 2**WIDTH-entry array; head/tail pointers are WIDTH+1 bits wide.
  - Empty when pointers are fully equal.
  - Full when low WIDTH bits are equal and MSBs differ.
  - Pointers wrap naturally modulo 2**(WIDTH+1).
- Reset (rst_n low, async): head=tail=0, count=0, almost_full=0. While rst_n is low, wready=0 and rvalid=0. Array contents are not reset; rdata is don't-care while rvalid=0.
- Write fires on wvalid&&wready: mem[tail]<=wdata, tail+1.
- Read fires on rvalid&&rready: head+1, except the fall-through bypass case below.
- wready = rst_n && !kill && !full.
  - No dependence on rready. A full queue refuses a write even when a read fires in the same cycle.
- rvalid (FALLTHROUGH=0) = rst_n && !kill && !empty; rdata = mem[head].
- rvalid (FALLTHROUGH=1) = rst_n && !kill && (!empty || wvalid). When empty, rdata = wdata combinationally.
  - If empty && wvalid && rready: the entry passes straight through. Neither pointer moves; count stays 0.
  - If empty && wvalid && !rready: the entry is stored normally; rdata = mem[head] next cycle.
- Simultaneous read+write when neither empty nor full: both pointers advance; count unchanged.
- count_next = count + write_fire − read_fire, excluding the bypass case. Registered; never exceeds 2**WIDTH and never underflows.
- almost_full_next = (count_next >= AFULL_LEVEL). Registered, aligned with count.
- kill (priority over everything):
  - Next edge: head<=tail, count<=0, almost_full<=0.
  - The same-cycle write is not accepted (wready=0) and no read fires (rvalid=0).
- Latency: write-to-rvalid is 1 cycle for FALLTHROUGH=0 and 0 cycles for FALLTHROUGH=1 into an empty queue.
- Throughput: 1 write and 1 read per cycle sustained.
- Ordering: strict FIFO. No entry is lost or duplicated except through kill.
- rst_n asserted mid-operation empties the queue immediately. Stale array data must never become visible after deassertion.

Test Plan:
- WIDTH=2, FALLTHROUGH=0: reset, then write 0x11,0x22,0x33,0x44 with rready=0 → wready drops after the 4th write, count=4, almost_full=1 from the cycle after the 2nd write. Then rready=1 → reads 0x11..0x44 in order, rvalid=0 with count=0 afterwards.
- WIDTH=2, full queue, wvalid=1 and rready=1 in the same cycle → read of head succeeds, write is refused (wready=0), count=3 next cycle.
- FALLTHROUGH=1, empty queue: wvalid=1, wdata=0xAB, rready=1 → rvalid=1 and rdata=0xAB in the same cycle, count stays 0. Repeat with rready=0 → entry stored, count=1, rdata=0xAB next cycle.
- Queue holding 3 entries, kill=1 with wvalid=1 → wready=0, rvalid=0 that cycle; next cycle count=0, rvalid=0, almost_full=0. The following write of 0x55 is the next value read.
- Wrap-around, WIDTH=2: 20 interleaved read/write cycles with a random valid/ready pattern → output sequence matches the scoreboard and count matches the model every cycle.
- Assert rst_n low asynchronously mid-cycle with 2 entries stored → rvalid=0, wready=0, count=0 immediately. After release, wready=1, rvalid=0 and no old data appears.

Source files
------------

// File: rtl/sync_queue_counted_if.sv
// Handshake bundle for sync_queue_counted: write side, read side, flush and occupancy status.
// master drives the requests (producer/consumer/pipeline control); slave is the queue itself.
interface sync_queue_counted_if #(
    parameter int DATA_SIZE = 32,
    parameter int WIDTH     = 4
);
    logic                 kill;
    logic                 wready;
    logic                 wvalid;
    logic [DATA_SIZE-1:0] wdata;
    logic                 rready;
    logic                 rvalid;
    logic [DATA_SIZE-1:0] rdata;
    logic [WIDTH:0]       count;
    logic                 almost_full;

    modport master (
        output kill, wvalid, wdata, rready,
        input  wready, rvalid, rdata, count, almost_full
    );

    modport slave (
        input  kill, wvalid, wdata, rready,
        output wready, rvalid, rdata, count, almost_full
    );
endinterface

// File: rtl/sync_queue_counted.sv
// Synchronous FIFO, 2**WIDTH entries, registered count/almost_full, kill flush, optional fall-through.
// Latency: write-to-rvalid 1 cycle (0 with FALLTHROUGH into empty); wready drops only on full/kill/reset.
module sync_queue_counted #(
    parameter int DATA_SIZE   = 32,
    parameter int WIDTH       = 4,
    parameter int AFULL_LEVEL = 2**WIDTH - 2,
    parameter int FALLTHROUGH = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_queue_counted_if.slave q
);
    localparam int             DEPTH   = 2**WIDTH;
    localparam logic [WIDTH:0] PTR_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] AFULL_Q = (WIDTH+1)'(AFULL_LEVEL);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [WIDTH:0]       head;
    logic [WIDTH:0]       tail;
    logic [WIDTH:0]       cnt;
    logic                 afull;
    logic [WIDTH:0]       cnt_next;
    logic                 empty;
    logic                 full;
    logic                 wfire;
    logic                 rfire;
    logic                 bypass;
    logic                 wr_en;
    logic                 rd_en;

    // Extra pointer MSB distinguishes full from empty so every slot is usable.
    assign empty = (head == tail);
    assign full  = (head[WIDTH-1:0] == tail[WIDTH-1:0]) && (head[WIDTH] != tail[WIDTH]);

    assign q.wready = rst_n && !q.kill && !full;

    if (FALLTHROUGH != 0) begin : g_ft
        assign q.rvalid = rst_n && !q.kill && (!empty || q.wvalid);
        assign q.rdata  = empty ? q.wdata : mem[head[WIDTH-1:0]];
    end else begin : g_reg
        assign q.rvalid = rst_n && !q.kill && !empty;
        assign q.rdata  = mem[head[WIDTH-1:0]];
    end

    assign wfire  = q.wvalid && q.wready;
    assign rfire  = q.rvalid && q.rready;
    // A read of an empty queue can only fire through the bypass path; nothing is stored.
    assign bypass = wfire && rfire && empty;
    assign wr_en  = wfire && !bypass;
    assign rd_en  = rfire && !bypass;

    assign cnt_next = cnt + {{WIDTH{1'b0}}, wr_en} - {{WIDTH{1'b0}}, rd_en};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            afull <= 1'b0;
        end else if (q.kill) begin
            head  <= tail;
            cnt   <= '0;
            afull <= 1'b0;
        end else begin
            if (wr_en) tail <= tail + PTR_ONE;
            if (rd_en) head <= head + PTR_ONE;
            cnt   <= cnt_next;
            afull <= (cnt_next >= AFULL_Q);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[tail[WIDTH-1:0]] <= q.wdata;
    end

    assign q.count       = cnt;
    assign q.almost_full = afull;
endmodule

// File: tb/tb_sync_queue_counted.sv
// Directed bench for sync_queue_counted: WIDTH=2 registered-output and fall-through instances.
module tb_sync_queue_counted;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sync_queue_counted_if #(.DATA_SIZE(32), .WIDTH(2)) q0 ();
    sync_queue_counted_if #(.DATA_SIZE(32), .WIDTH(2)) q1 ();

    sync_queue_counted #(.DATA_SIZE(32), .WIDTH(2), .AFULL_LEVEL(2), .FALLTHROUGH(0))
        u_q0 (.clk(clk), .rst_n(rst_n), .q(q0));
    sync_queue_counted #(.DATA_SIZE(32), .WIDTH(2), .AFULL_LEVEL(2), .FALLTHROUGH(1))
        u_q1 (.clk(clk), .rst_n(rst_n), .q(q1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic wv, input logic [31:0] wd, input logic rr, input logic kl);
        q0.wvalid = wv;
        q0.wdata  = wd;
        q0.rready = rr;
        q0.kill   = kl;
        #1;
    endtask

    logic [31:0] vals [4];
    logic [31:0] sb [$];
    logic [19:0] wv_pat;
    logic [19:0] rr_pat;
    int          mc;
    logic        wf;
    logic        rf;

    initial begin
        rst_n = 1'b0;
        drv0(1'b0, 32'h0, 1'b0, 1'b0);
        q1.wvalid = 1'b0; q1.wdata = '0; q1.rready = 1'b0; q1.kill = 1'b0;
        #1;
        chk("rst_wready", {31'b0, q0.wready}, 32'd0);
        chk("rst_rvalid", {31'b0, q0.rvalid}, 32'd0);
        chk("rst_count", {29'b0, q0.count}, 32'd0);
        chk("rst_afull", {31'b0, q0.almost_full}, 32'd0);
        #5 rst_n = 1'b1;
        tick();

        // Fill four entries with no reader.
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int k = 0; k < 4; k++) begin
            drv0(1'b1, vals[k], 1'b0, 1'b0);
            chk("fill_wready", {31'b0, q0.wready}, 32'd1);
            chk("fill_rvalid", {31'b0, q0.rvalid}, (k == 0) ? 32'd0 : 32'd1);
            tick();
            chk("fill_count", {29'b0, q0.count}, k + 1);
            chk("fill_afull", {31'b0, q0.almost_full}, (k >= 1) ? 32'd1 : 32'd0);
        end
        drv0(1'b1, 32'h99, 1'b0, 1'b0);
        chk("full_wready", {31'b0, q0.wready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            drv0(1'b0, 32'h0, 1'b1, 1'b0);
            chk("drain_rvalid", {31'b0, q0.rvalid}, 32'd1);
            chk("drain_rdata", q0.rdata, vals[k]);
            tick();
            chk("drain_count", {29'b0, q0.count}, 3 - k);
            chk("drain_afull", {31'b0, q0.almost_full}, (k <= 1) ? 32'd1 : 32'd0);
        end
        drv0(1'b0, 32'h0, 1'b1, 1'b0);
        chk("empty_rvalid", {31'b0, q0.rvalid}, 32'd0);

        // Full queue with simultaneous read and write: write refused.
        for (int k = 0; k < 4; k++) begin
            drv0(1'b1, 32'hA0 + k, 1'b0, 1'b0);
            tick();
        end
        drv0(1'b1, 32'hEE, 1'b1, 1'b0);
        chk("fullrw_wready", {31'b0, q0.wready}, 32'd0);
        chk("fullrw_rvalid", {31'b0, q0.rvalid}, 32'd1);
        chk("fullrw_rdata", q0.rdata, 32'hA0);
        tick();
        chk("fullrw_count", {29'b0, q0.count}, 32'd3);
        for (int k = 1; k < 4; k++) begin
            drv0(1'b0, 32'h0, 1'b1, 1'b0);
            chk("fullrw_order", q0.rdata, 32'hA0 + k);
            tick();
        end
        drv0(1'b0, 32'h0, 1'b0, 1'b0);
        chk("fullrw_empty", {31'b0, q0.rvalid}, 32'd0);

        // Kill with three entries stored and a concurrent write.
        for (int k = 0; k < 3; k++) begin
            drv0(1'b1, 32'h1 + k, 1'b0, 1'b0);
            tick();
        end
        drv0(1'b1, 32'h77, 1'b0, 1'b1);
        chk("kill_wready", {31'b0, q0.wready}, 32'd0);
        chk("kill_rvalid", {31'b0, q0.rvalid}, 32'd0);
        tick();
        drv0(1'b0, 32'h0, 1'b0, 1'b0);
        chk("kill_count", {29'b0, q0.count}, 32'd0);
        chk("kill_rvalid_after", {31'b0, q0.rvalid}, 32'd0);
        chk("kill_afull", {31'b0, q0.almost_full}, 32'd0);
        drv0(1'b1, 32'h55, 1'b0, 1'b0);
        tick();
        drv0(1'b0, 32'h0, 1'b1, 1'b0);
        chk("kill_next_rvalid", {31'b0, q0.rvalid}, 32'd1);
        chk("kill_next_rdata", q0.rdata, 32'h55);
        tick();
        drv0(1'b0, 32'h0, 1'b0, 1'b0);

        // Fall-through into an empty queue, consumed and not consumed.
        q1.wvalid = 1'b1; q1.wdata = 32'hAB; q1.rready = 1'b1;
        #1;
        chk("ft_rvalid", {31'b0, q1.rvalid}, 32'd1);
        chk("ft_rdata", q1.rdata, 32'hAB);
        tick();
        q1.wvalid = 1'b0; q1.rready = 1'b0;
        #1;
        chk("ft_count", {29'b0, q1.count}, 32'd0);
        chk("ft_rvalid_after", {31'b0, q1.rvalid}, 32'd0);
        q1.wvalid = 1'b1; q1.wdata = 32'hAB; q1.rready = 1'b0;
        #1;
        chk("ft_hold_rvalid", {31'b0, q1.rvalid}, 32'd1);
        tick();
        q1.wvalid = 1'b0; q1.wdata = 32'h0;
        #1;
        chk("ft_store_count", {29'b0, q1.count}, 32'd1);
        chk("ft_store_rvalid", {31'b0, q1.rvalid}, 32'd1);
        chk("ft_store_rdata", q1.rdata, 32'hAB);
        q1.rready = 1'b1;
        tick();
        q1.rready = 1'b0;
        #1;
        chk("ft_drain_count", {29'b0, q1.count}, 32'd0);

        // Wrap-around with a fixed interleaved valid/ready pattern against a scoreboard.
        wv_pat = 20'b1011_0111_1101_1110_1111;
        rr_pat = 20'b1110_1101_0011_1011_0100;
        mc = 0;
        for (int i = 0; i < 20; i++) begin
            drv0(wv_pat[i], 32'h100 + i, rr_pat[i], 1'b0);
            chk("wrap_wready", {31'b0, q0.wready}, (mc < 4) ? 32'd1 : 32'd0);
            chk("wrap_rvalid", {31'b0, q0.rvalid}, (mc > 0) ? 32'd1 : 32'd0);
            if (mc > 0) chk("wrap_rdata", q0.rdata, sb[0]);
            wf = wv_pat[i] && (mc < 4);
            rf = rr_pat[i] && (mc > 0);
            if (rf) void'(sb.pop_front());
            if (wf) sb.push_back(32'h100 + i);
            mc = mc + int'(wf) - int'(rf);
            tick();
            chk("wrap_count", {29'b0, q0.count}, mc);
            chk("wrap_afull", {31'b0, q0.almost_full}, (mc >= 2) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset mid-cycle with two entries stored.
        drv0(1'b0, 32'h0, 1'b0, 1'b0);
        while (mc > 0) begin
            drv0(1'b0, 32'h0, 1'b1, 1'b0);
            tick();
            mc--;
        end
        for (int k = 0; k < 2; k++) begin
            drv0(1'b1, 32'hC0 + k, 1'b0, 1'b0);
            tick();
        end
        drv0(1'b1, 32'hDD, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rvalid", {31'b0, q0.rvalid}, 32'd0);
        chk("arst_wready", {31'b0, q0.wready}, 32'd0);
        chk("arst_count", {29'b0, q0.count}, 32'd0);
        drv0(1'b0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rel_wready", {31'b0, q0.wready}, 32'd1);
        chk("rel_rvalid", {31'b0, q0.rvalid}, 32'd0);
        tick();
        chk("rel_rvalid_next", {31'b0, q0.rvalid}, 32'd0);
        chk("rel_count_next", {29'b0, q0.count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
